// File: rtl/lcd_timing_pkg.sv
// Shared timing definitions for the RGB565 parallel LCD path.
// Used by lcd_timing_driver and by the upstream lcd_display stage.
package lcd_timing_pkg;

   // Width of one RGB565 pixel word.
   localparam int RGB_W = 16;

   // Width of the horizontal/vertical counters and the pixel coordinates.
   localparam int CNT_W = 11;

   // Largest line or frame total that still fits in a CNT_W-bit counter.
   localparam int unsigned CNT_MAX = 2047;

   // One complete panel timing set. Horizontal values are in clocks and vertical values are in lines.
   typedef struct packed {
      int unsigned h_sync;
      int unsigned h_back;
      int unsigned h_disp;
      int unsigned h_front;
      int unsigned v_sync;
      int unsigned v_back;
      int unsigned v_disp;
      int unsigned v_front;
   } panel_timing_t;

   // 4.3 inch 480x272 panel. These values are the driver defaults.
   localparam panel_timing_t PANEL_480X272 = '{
      h_sync:  41, h_back: 2,  h_disp: 480, h_front: 2,
      v_sync:  10, v_back: 2,  v_disp: 272, v_front: 2
   };

   // 7 inch 800x480 panel.
   localparam panel_timing_t PANEL_800X480 = '{
      h_sync:  128, h_back: 88, h_disp: 800, h_front: 40,
      v_sync:  2,   v_back: 33, v_disp: 480, v_front: 10
   };

   // Total period of one axis: sync, back porch, active region and front porch.
   function automatic int unsigned span_total(input int unsigned sync_w,
                                              input int unsigned back_w,
                                              input int unsigned disp_w,
                                              input int unsigned front_w);
      return sync_w + back_w + disp_w + front_w;
   endfunction

endpackage

// File: rtl/lcd_mod_cnt.sv
// Modulo-N up counter with a count enable.
// The wrap output is high during the enabled cycle in which the counter returns to zero.
// That lets a second counter chain off it with no extra register stage.
module lcd_mod_cnt
   import lcd_timing_pkg::*;
#(
   parameter int unsigned MODULUS = 2,
   parameter int unsigned WIDTH   = CNT_W
) (
   input  logic             lcd_clk,
   input  logic             sys_rst_n,
   input  logic             en,
   output logic [WIDTH-1:0] cnt,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] LAST = WIDTH'(MODULUS - 1);

   assign wrap = en && (cnt == LAST);

   // Count enabled cycles and fold back to zero after the last value.
   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         cnt <= '0;
      end else if (wrap) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= cnt + WIDTH'(1);
      end
   end

endmodule

// File: rtl/lcd_timing_driver.sv
// Timing generator and pixel sink for the RGB565 parallel LCD panel.
// It requests pixel coordinates one clock ahead of data enable. The pixel word returned
// by lcd_display then lines up with lcd_de with no extra pipelining in this block.
module lcd_timing_driver
   import lcd_timing_pkg::*;
#(
   parameter int unsigned H_SYNC  = PANEL_480X272.h_sync,
   parameter int unsigned H_BACK  = PANEL_480X272.h_back,
   parameter int unsigned H_DISP  = PANEL_480X272.h_disp,
   parameter int unsigned H_FRONT = PANEL_480X272.h_front,
   parameter int unsigned V_SYNC  = PANEL_480X272.v_sync,
   parameter int unsigned V_BACK  = PANEL_480X272.v_back,
   parameter int unsigned V_DISP  = PANEL_480X272.v_disp,
   parameter int unsigned V_FRONT = PANEL_480X272.v_front
) (
   input  logic             lcd_clk,
   input  logic             sys_rst_n,
   input  logic [RGB_W-1:0] pixel_data,
   output logic [CNT_W-1:0] pixel_xpos,
   output logic [CNT_W-1:0] pixel_ypos,
   output logic             lcd_hs,
   output logic             lcd_vs,
   output logic             lcd_de,
   output logic [RGB_W-1:0] lcd_rgb,
   output logic             lcd_bl,
   output logic             frame_start
);

   localparam int unsigned H_TOTAL = span_total(H_SYNC, H_BACK, H_DISP, H_FRONT);
   localparam int unsigned V_TOTAL = span_total(V_SYNC, V_BACK, V_DISP, V_FRONT);

   // The request window opens one clock before the first active pixel.
   // So sync plus back porch must leave room for it, and the counters must hold the totals.
   if ((H_SYNC + H_BACK < 2) || (V_SYNC + V_BACK < 1) ||
       (H_TOTAL > CNT_MAX) || (V_TOTAL > CNT_MAX)) begin : g_param_check
      $error("lcd_timing_driver: illegal panel timing parameters");
   end

   // Decode boundaries, pre-sized to the counter width.
   localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] H_REQ_BEG  = CNT_W'(H_SYNC + H_BACK - 1);
   localparam logic [CNT_W-1:0] H_REQ_END  = CNT_W'(H_SYNC + H_BACK + H_DISP - 1);
   localparam logic [CNT_W-1:0] H_DE_BEG   = CNT_W'(H_SYNC + H_BACK);
   localparam logic [CNT_W-1:0] H_DE_END   = CNT_W'(H_SYNC + H_BACK + H_DISP);
   localparam logic [CNT_W-1:0] X_OFFSET   = CNT_W'(H_SYNC + H_BACK - 2);
   localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BACK);
   localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BACK + V_DISP);
   localparam logic [CNT_W-1:0] Y_OFFSET   = CNT_W'(V_SYNC + V_BACK - 1);

   logic [CNT_W-1:0] h_cnt;
   logic [CNT_W-1:0] v_cnt;
   logic             h_wrap;
   logic             v_wrap;
   logic             v_active;
   logic             h_req;
   logic             h_de;
   logic             req;

   // The backlight register also serves as the "running" flag.
   // The counters hold at zero until the first edge after reset so the frame restarts cleanly at h_cnt=0.
   lcd_mod_cnt #(
      .MODULUS (H_TOTAL),
      .WIDTH   (CNT_W)
   ) u_h_cnt (
      .lcd_clk   (lcd_clk),
      .sys_rst_n (sys_rst_n),
      .en        (lcd_bl),
      .cnt       (h_cnt),
      .wrap      (h_wrap)
   );

   lcd_mod_cnt #(
      .MODULUS (V_TOTAL),
      .WIDTH   (CNT_W)
   ) u_v_cnt (
      .lcd_clk   (lcd_clk),
      .sys_rst_n (sys_rst_n),
      .en        (h_wrap),
      .cnt       (v_cnt),
      .wrap      (v_wrap)
   );

   // Turn the backlight on at the first edge after reset.
   // Flag frame_start on that edge and on every full-frame wrap, since both leave the counters at 0,0.
   always_ff @(posedge lcd_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
         lcd_bl      <= 1'b0;
         frame_start <= 1'b0;
      end else begin
         lcd_bl      <= 1'b1;
         frame_start <= v_wrap || !lcd_bl;
      end
   end

   // Decode sync, the one-clock-early request window, data enable and the requested coordinates from the counters.
   always_comb begin
      v_active   = (v_cnt >= V_ACT_BEG) && (v_cnt < V_ACT_END);
      h_req      = (h_cnt >= H_REQ_BEG) && (h_cnt < H_REQ_END);
      h_de       = (h_cnt >= H_DE_BEG) && (h_cnt < H_DE_END);
      req        = v_active && h_req;
      lcd_hs     = (h_cnt >= H_SYNC_END);
      lcd_vs     = (v_cnt >= V_SYNC_END);
      lcd_de     = v_active && h_de;
      pixel_xpos = req ? (h_cnt - X_OFFSET) : '0;
      pixel_ypos = req ? (v_cnt - Y_OFFSET) : '0;
   end

   // Pass the returned pixel word to the panel only while data enable is high.
   always_comb begin
      lcd_rgb = lcd_de ? pixel_data : '0;
   end

endmodule
